// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues word fetches, buffers in-order responses in a
// 2-entry queue and feeds the IF/ID register, handling redirects, stalls and HALT.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        halted
);

  localparam logic [2:0] SLOTS       = 3'(BUF_DEPTH);
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  logic [31:0] fetch_pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop_cnt;
  logic [1:0]  buf_count;
  logic [31:0] buf0_instr, buf0_pc, buf1_instr, buf1_pc;

  logic        req_fire, rsp_keep;
  logic        load_valid, halt_load, buf_pop, buf_push;
  logic [31:0] rsp_pc, load_instr, load_pc;

  assign imem_req_valid = rst_n && !halted && !redirect_valid &&
                          (({1'b0, outstanding} + {1'b0, buf_count}) < SLOTS);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Live requests since the last redirect are contiguous and end at fetch_pc-4,
  // so the oldest one in flight sits `outstanding` words behind fetch_pc.
  assign rsp_pc   = fetch_pc - {28'd0, outstanding, 2'b00};
  assign rsp_keep = imem_rsp_valid && (drop_cnt == 2'd0) && !halted && !redirect_valid;

  always_comb begin
    load_valid = 1'b0;
    load_instr = buf0_instr;
    load_pc    = buf0_pc;
    if (!redirect_valid && !id_stall) begin
      if (buf_count != 2'd0) begin
        load_valid = 1'b1;
      end else if (rsp_keep) begin
        load_valid = 1'b1;
        load_instr = imem_rsp_data;
        load_pc    = rsp_pc;
      end
    end
    halt_load = load_valid && (load_instr[31:26] == HALT_OPCODE);
    buf_pop   = load_valid && (buf_count != 2'd0);
    buf_push  = rsp_keep && !halt_load && !(load_valid && (buf_count == 2'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
      halted      <= 1'b0;
    end else begin
      if (redirect_valid)
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;

      case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase

      // Everything still in flight at a redirect belongs to the old stream.
      if (redirect_valid)
        drop_cnt <= (imem_rsp_valid && (outstanding != 2'd0)) ? outstanding - 2'd1 : outstanding;
      else if (imem_rsp_valid && (drop_cnt != 2'd0))
        drop_cnt <= drop_cnt - 2'd1;

      if (halt_load)
        halted <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_count  <= 2'd0;
      buf0_instr <= 32'd0;
      buf0_pc    <= 32'd0;
      buf1_instr <= 32'd0;
      buf1_pc    <= 32'd0;
    end else if (redirect_valid || halt_load) begin
      buf_count <= 2'd0;
    end else begin
      case ({buf_pop, buf_push})
        2'b10: begin
          buf0_instr <= buf1_instr;
          buf0_pc    <= buf1_pc;
          buf_count  <= buf_count - 2'd1;
        end
        2'b01: begin
          if (buf_count == 2'd0) begin
            buf0_instr <= imem_rsp_data;
            buf0_pc    <= rsp_pc;
          end else begin
            buf1_instr <= imem_rsp_data;
            buf1_pc    <= rsp_pc;
          end
          buf_count <= buf_count + 2'd1;
        end
        2'b11: begin
          if (buf_count == 2'd1) begin
            buf0_instr <= imem_rsp_data;
            buf0_pc    <= rsp_pc;
          end else begin
            buf0_instr <= buf1_instr;
            buf0_pc    <= buf1_pc;
            buf1_instr <= imem_rsp_data;
            buf1_pc    <= rsp_pc;
          end
        end
        default: buf_count <= buf_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid    <= 1'b0;
      ifid_instr    <= 32'd0;
      ifid_pc       <= 32'd0;
      ifid_pc_plus4 <= 32'd0;
    end else if (redirect_valid) begin
      ifid_valid <= 1'b0;
    end else if (!id_stall) begin
      ifid_valid <= load_valid;
      if (load_valid) begin
        ifid_instr    <= load_instr;
        ifid_pc       <= load_pc;
        ifid_pc_plus4 <= load_pc + 32'd4;
      end
    end
  end

  // The issue throttle guarantees a free slot for every response in flight.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(imem_rsp_valid && (buf_count == 2'd2)));

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2, SHALL set the response buffer depth; the only supported value is 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous, active-low.
REQ-005 imem_req_valid  output  1  SHALL indicate a fetch request.
REQ-006 imem_req_addr  output  32  SHALL carry the word-aligned fetch address.
REQ-007 imem_req_ready  input  1  SHALL indicate memory accepts a request.
REQ-008 imem_rsp_valid  input  1  SHALL indicate return data; responses arrive in request order.
REQ-009 imem_rsp_data  input  32  SHALL carry the instruction word.
REQ-010 id_stall  input  1  SHALL hold the IF/ID register when high.
REQ-011 redirect_valid  input  1  SHALL request a PC change (jump/branch).
REQ-012 redirect_pc  input  32  SHALL carry the redirect target.
REQ-013 ifid_valid  output  1  SHALL mark ifid_* as holding a live instruction.
REQ-014 ifid_instr  output  32  SHALL carry the instruction to decode.
REQ-015 ifid_pc  output  32  SHALL carry that instruction's address.
REQ-016 ifid_pc_plus4  output  32  SHALL carry ifid_pc + 4 (mod 2^32).
REQ-017 halted  output  1  SHALL indicate fetch has stopped on HALT.

Function
REQ-018 Request accepted when imem_req_valid && imem_req_ready; on acceptance fetch PC SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-019 imem_req_valid SHALL be high only when outstanding + buffered < 2, halted = 0, and redirect_valid = 0.
REQ-020 Outstanding counter (0..2) SHALL increment on acceptance and decrement on each response; simultaneous accept and response SHALL leave it unchanged.
REQ-021 Each response SHALL be pushed, with its PC, into a 2-entry in-order buffer unless discarded per REQ-025.
REQ-022 IF/ID register SHALL load the buffer head when id_stall = 0 and the buffer is non-empty; it SHALL set ifid_valid = 0 when id_stall = 0 and the buffer is empty.
REQ-023 When id_stall = 1 all ifid_* outputs SHALL hold; buffer and in-flight responses SHALL be retained.
REQ-024 Response arriving at an empty buffer while id_stall = 0 SHALL reach ifid_* on the following edge (1-cycle response-to-IF/ID latency).
REQ-025 On redirect_valid: fetch PC <= {redirect_pc[31:2], 2'b00}; buffer cleared; ifid_valid <= 0 regardless of id_stall; drop counter <= current outstanding count; subsequent responses SHALL be discarded while drop counter > 0, each decrementing it.
REQ-026 Redirect SHALL take priority over stall, buffer push, and halt detection in the same cycle.
REQ-027 A request SHALL issue from the new PC no earlier than the cycle after redirect_valid.
REQ-028 When an instruction with [31:26] = 6'b111111 loads into IF/ID, halted SHALL set the same edge; no further requests SHALL issue; remaining buffer contents and later responses SHALL be discarded.
REQ-029 halted SHALL be sticky until reset; redirect SHALL NOT clear it.
REQ-030 Buffer overflow SHALL be impossible by REQ-019; a response with buffer full SHALL be flagged by an assertion.

Reset
REQ-031 On rst_n low, asynchronously: fetch PC = RESET_PC, outstanding = 0, drop = 0, buffer empty, ifid_valid = 0, ifid_instr = 0, ifid_pc = 0, ifid_pc_plus4 = 0, halted = 0, imem_req_valid = 0.
REQ-032 First request SHALL issue the first cycle after rst_n deasserts, at RESET_PC.
REQ-033 Reset mid-operation SHALL discard all in-flight and buffered instructions; stale responses arriving after reset SHALL be ignored only if memory is also reset (system requirement).

Verification
REQ-034 Zero-wait memory, no stall -> ifid_pc sequence 0,4,8,12 on consecutive cycles; ifid_pc_plus4 = ifid_pc + 4.
REQ-035 id_stall high 3 cycles with buffer full -> ifid_* constant, imem_req_valid = 0, no instruction lost or duplicated after release.
REQ-036 redirect_pc = 32'h0000_0103 with 2 outstanding -> both stale responses dropped, next request addr 32'h0000_0100, ifid_valid low until its response.
REQ-037 imem_rsp_data = 32'hFC00_0000 loaded -> halted = 1, imem_req_valid = 0 thereafter, ifid_valid low after next non-stalled edge.
REQ-038 redirect_valid and HALT load in same cycle -> halted stays 0, fetch resumes at redirect target.
REQ-039 rst_n pulsed low mid-stream -> all outputs at reset values immediately; first post-reset request addr = RESET_PC.
